// File: rtl/sabr_mul_pkg.sv
// Shared types and helpers for the SABR pipelined multiplier.
// Contents: MUL_MAX_STAGE (deepest legal pipeline), mul_prod_width()
// (full-precision product width), mul_mode_e (operand signedness mode).
package sabr_mul_pkg;

  localparam int unsigned MUL_MAX_STAGE = 8;

  // Operand signedness, indexed by {din0_sgn, din1_sgn}
  typedef enum logic [1:0] {
    UU = 2'b00,
    US = 2'b01,
    SU = 2'b10,
    SS = 2'b11
  } mul_mode_e;

  // One extra bit so that every mixed-sign product fits as a signed value
  function automatic int unsigned mul_prod_width(input int unsigned w0, input int unsigned w1);
    return w0 + w1 + 1;
  endfunction

endpackage

// File: rtl/sabr_mul_pipe_if.sv
// Operand/result handshake bundle for sabr_mul_pipe.
// master: drives operands and out_ready, observes in_ready and results.
// slave : the multiplier side.
//   in_valid/in_ready        operand beat handshake
//   din0, din1               operands A and B
//   din0_sgn, din1_sgn       1 = two's complement, 0 = unsigned
//   out_valid/out_ready      result beat handshake
//   dout, ovf                product and out-of-range flag
interface sabr_mul_pipe_if #(
  parameter int unsigned DIN0_WIDTH = 83,
  parameter int unsigned DIN1_WIDTH = 6,
  parameter int unsigned DOUT_WIDTH = 89
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  din0_sgn;
  logic                  din1_sgn;
  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  ovf;

  modport master (
    output in_valid, din0, din1, din0_sgn, din1_sgn, out_ready,
    input  in_ready, out_valid, dout, ovf
  );

  modport slave (
    input  in_valid, din0, din1, din0_sgn, din1_sgn, out_ready,
    output in_ready, out_valid, dout, ovf
  );

endinterface

// File: rtl/sabr_mul_core.sv
// Combinational multiply core: extends each operand by its sign mode,
// forms the full-precision signed product, flags results that do not fit
// DOUT_WIDTH and either wraps or saturates.
// Build option: SABR_MUL_SAT_EN saturates dout on overflow; otherwise wrap.
// Ports:
//   din0, din1          operands
//   din0_sgn, din1_sgn  per-operand signedness
//   dout_c              wrapped or saturated product (combinational)
//   ovf_c               product outside the result range (combinational)
module sabr_mul_core
  import sabr_mul_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = 83,
  parameter int unsigned DIN1_WIDTH = 6,
  parameter int unsigned DOUT_WIDTH = 89
) (
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  din0_sgn,
  input  logic                  din1_sgn,
  output logic [DOUT_WIDTH-1:0] dout_c,
  output logic                  ovf_c
);

  localparam int unsigned PW = mul_prod_width(DIN0_WIDTH, DIN1_WIDTH);

  mul_mode_e            mode_c;
  logic signed [PW-1:0] a_ext_c;
  logic signed [PW-1:0] b_ext_c;
  logic signed [PW-1:0] prod_c;
  logic                 sig_fit_c;
  logic                 uns_fit_c;

  // Extend, multiply, range check, then wrap or clamp
  always_comb begin
    mode_c    = mul_mode_e'({din0_sgn, din1_sgn});
    a_ext_c   = {{(PW-DIN0_WIDTH){din0_sgn & din0[DIN0_WIDTH-1]}}, din0};
    b_ext_c   = {{(PW-DIN1_WIDTH){din1_sgn & din1[DIN1_WIDTH-1]}}, din1};
    prod_c    = a_ext_c * b_ext_c;
    // Signed fit: all bits from the result MSB upward agree with the sign
    sig_fit_c = (prod_c[PW-1:DOUT_WIDTH-1] == '0) || (prod_c[PW-1:DOUT_WIDTH-1] == '1);
    // Unsigned fit only matters for UU, where the product is never negative
    uns_fit_c = (prod_c[PW-1:DOUT_WIDTH] == '0);
    ovf_c     = (mode_c == UU) ? ~uns_fit_c : ~sig_fit_c;
    dout_c    = prod_c[DOUT_WIDTH-1:0];
`ifdef SABR_MUL_SAT_EN
    if (ovf_c) begin
      if (mode_c == UU) begin
        dout_c = '1;
      end else begin
        dout_c = {prod_c[PW-1], {(DOUT_WIDTH-1){~prod_c[PW-1]}}};
      end
    end
`endif
  end

endmodule

// File: rtl/sabr_mul_pipe.sv
// Pipelined SABR integer multiplier with valid/ready flow control.
// The multiply sits in front of stage 1; later stages only retime the
// result. A stalled output freezes every stage (global stall, no bubble
// compression). Latency is NUM_STAGE cycles.
// Build option: SABR_MUL_SAT_EN (saturate on overflow, see sabr_mul_core).
// Ports:
//   ap_clk    clock, rising edge
//   ap_rst_n  asynchronous active-low reset, flushes in-flight beats
//   bus       sabr_mul_pipe_if slave: operand and result handshakes
module sabr_mul_pipe
  import sabr_mul_pkg::*;
#(
  parameter int unsigned DIN0_WIDTH = 83,
  parameter int unsigned DIN1_WIDTH = 6,
  parameter int unsigned DOUT_WIDTH = 89,
  parameter int unsigned NUM_STAGE  = 3
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  sabr_mul_pipe_if.slave bus
);

  // Elaboration-time parameter legality
  if ((NUM_STAGE < 1) || (NUM_STAGE > MUL_MAX_STAGE)) begin : g_bad_stage
    $error("sabr_mul_pipe: NUM_STAGE=%0d outside 1..%0d", NUM_STAGE, MUL_MAX_STAGE);
  end
  if (DOUT_WIDTH > DIN0_WIDTH + DIN1_WIDTH) begin : g_bad_width
    $error("sabr_mul_pipe: DOUT_WIDTH=%0d exceeds DIN0_WIDTH+DIN1_WIDTH", DOUT_WIDTH);
  end

  logic                  adv_c;
  logic [DOUT_WIDTH-1:0] mul_dout_c;
  logic                  mul_ovf_c;

  sabr_mul_core #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH)
  ) u_core (
    .din0     (bus.din0),
    .din1     (bus.din1),
    .din0_sgn (bus.din0_sgn),
    .din1_sgn (bus.din1_sgn),
    .dout_c   (mul_dout_c),
    .ovf_c    (mul_ovf_c)
  );

  // Stage chain; data only loads with a valid beat so outputs stay quiet
  // across bubbles
  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_st
    logic                  vld_d;
    logic                  ovf_d;
    logic [DOUT_WIDTH-1:0] dat_d;
    logic                  vld_q;
    logic                  ovf_q;
    logic [DOUT_WIDTH-1:0] dat_q;

    if (k == 0) begin : g_head
      assign vld_d = bus.in_valid;
      assign ovf_d = mul_ovf_c;
      assign dat_d = mul_dout_c;
    end else begin : g_tail
      assign vld_d = g_st[k-1].vld_q;
      assign ovf_d = g_st[k-1].ovf_q;
      assign dat_d = g_st[k-1].dat_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        vld_q <= 1'b0;
        ovf_q <= 1'b0;
        dat_q <= '0;
      end else if (adv_c) begin
        vld_q <= vld_d;
        if (vld_d) begin
          ovf_q <= ovf_d;
          dat_q <= dat_d;
        end
      end
    end
  end

  // Whole pipe moves unless the head result is held by the consumer
  assign adv_c        = ~g_st[NUM_STAGE-1].vld_q | bus.out_ready;
  assign bus.in_ready = adv_c;

  assign bus.out_valid = g_st[NUM_STAGE-1].vld_q;
  assign bus.dout      = g_st[NUM_STAGE-1].dat_q;
  assign bus.ovf       = g_st[NUM_STAGE-1].ovf_q;

endmodule

// File: tb/tb_sabr_mul_pipe.sv
// Bench for sabr_mul_pipe: three instances sharing one stimulus stream
//   0: 8x8 -> 16, NUM_STAGE=3   1: 8x8 -> 12, NUM_STAGE=1   2: 8x8 -> 12, NUM_STAGE=8
// Per-instance scoreboards compare every result against an arithmetic model.
module tb_sabr_mul_pipe;

  localparam int NB = 3;

`ifdef SABR_MUL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] dout;
    logic        ovf;
  } exp_t;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b1;
  logic       s0        = 1'b0;
  logic       s1        = 1'b0;
  logic [7:0] a         = 8'd0;
  logic [7:0] b         = 8'd0;
  int         total     = 0;
  int         bad       = 0;

  always #5 clk = ~clk;

  sabr_mul_pipe_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16)) bus_a ();
  sabr_mul_pipe_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(12)) bus_b ();
  sabr_mul_pipe_if #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(12)) bus_c ();

  assign bus_a.in_valid = in_valid;  assign bus_b.in_valid = in_valid;  assign bus_c.in_valid = in_valid;
  assign bus_a.din0     = a;         assign bus_b.din0     = a;         assign bus_c.din0     = a;
  assign bus_a.din1     = b;         assign bus_b.din1     = b;         assign bus_c.din1     = b;
  assign bus_a.din0_sgn = s0;        assign bus_b.din0_sgn = s0;        assign bus_c.din0_sgn = s0;
  assign bus_a.din1_sgn = s1;        assign bus_b.din1_sgn = s1;        assign bus_c.din1_sgn = s1;
  assign bus_a.out_ready = out_ready; assign bus_b.out_ready = out_ready; assign bus_c.out_ready = out_ready;

  sabr_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(16), .NUM_STAGE(3))
    dut_a (.ap_clk(clk), .ap_rst_n(rst_n), .bus(bus_a));
  sabr_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(12), .NUM_STAGE(1))
    dut_b (.ap_clk(clk), .ap_rst_n(rst_n), .bus(bus_b));
  sabr_mul_pipe #(.DIN0_WIDTH(8), .DIN1_WIDTH(8), .DOUT_WIDTH(12), .NUM_STAGE(8))
    dut_c (.ap_clk(clk), .ap_rst_n(rst_n), .bus(bus_c));

  logic        rdy_w [NB];
  logic        ov_w  [NB];
  logic        ovf_w [NB];
  logic [15:0] dv_w  [NB];

  assign rdy_w[0] = bus_a.in_ready;  assign ov_w[0] = bus_a.out_valid;
  assign rdy_w[1] = bus_b.in_ready;  assign ov_w[1] = bus_b.out_valid;
  assign rdy_w[2] = bus_c.in_ready;  assign ov_w[2] = bus_c.out_valid;
  assign ovf_w[0] = bus_a.ovf;       assign dv_w[0]  = bus_a.dout;
  assign ovf_w[1] = bus_b.ovf;       assign dv_w[1]  = 16'(bus_b.dout);
  assign ovf_w[2] = bus_c.ovf;       assign dv_w[2]  = 16'(bus_c.dout);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer product, range clamp or modulo into ow bits
  function automatic exp_t model(input logic [7:0] da, input logic [7:0] db,
                                 input logic sa, input logic sb, input int ow);
    longint pa, pb, p, lo, hi, r;
    exp_t   e;
    pa = sa ? longint'($signed(da)) : longint'(da);
    pb = sb ? longint'($signed(db)) : longint'(db);
    p  = pa * pb;
    if (!sa && !sb) begin
      lo = 0;
      hi = (longint'(1) << ow) - 1;
    end else begin
      lo = -(longint'(1) << (ow - 1));
      hi = (longint'(1) << (ow - 1)) - 1;
    end
    e.ovf  = (p < lo) || (p > hi);
    r      = p;
    if (e.ovf && SAT) r = (p < 0) ? lo : hi;
    e.dout = 16'(r & ((longint'(1) << ow) - 1));
    return e;
  endfunction

  // Scoreboard per instance: push on accept, pop and compare on delivery
  for (genvar g = 0; g < NB; g++) begin : g_mon
    localparam int OW = (g == 0) ? 16 : 12;
    exp_t q[$];
    exp_t e;
    always @(negedge clk) begin
      if (rst_n) begin
        if (in_valid && rdy_w[g]) q.push_back(model(a, b, s0, s1, OW));
        if (ov_w[g] && out_ready) begin
          total++;
          assert (q.size() != 0) else begin
            bad++;
            $error("FAIL sb%0d_extra observed=0x%0h expected=none", g, dv_w[g]);
          end
          if (q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("sb%0d_dout", g), 32'(dv_w[g]), 32'(e.dout));
            chk($sformatf("sb%0d_ovf", g), 32'(ovf_w[g]), 32'(e.ovf));
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] da, input logic [7:0] db,
                       input logic sa, input logic sb);
    in_valid = v; a = da; b = db; s0 = sa; s1 = sb;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Drain, send one beat, wait (bounded) for instance d to present it
  task automatic one_beat(input int d, input logic [7:0] da, input logic [7:0] db,
                          input logic sa, input logic sb,
                          output int lat, output logic [15:0] dv, output logic ov);
    idle(10);
    drive(1'b1, da, db, sa, sb);
    lat = 0; dv = '0; ov = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #2;
      in_valid = 1'b0;
      @(negedge clk);
      if (ov_w[d]) begin
        lat = k; dv = dv_w[d]; ov = ovf_w[d];
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    int          nout;
    int          first;
    int          last;
    logic [15:0] dv;
    logic        ov;
    logic [15:0] snap;
    exp_t        e;

    // Reset and idle outputs
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(ov_w[0]), 0);
      chk("rst_in_ready", 32'(rdy_w[0]), 1);
      chk("rst_ovf", 32'(ovf_w[0]), 0);
      chk("rst_dout", 32'(dv_w[0]), 0);
    end

    // Unsigned max, latency 3
    one_beat(0, 8'd255, 8'd255, 1'b0, 1'b0, lat, dv, ov);
    chk("uu_lat", 32'(lat), 3);
    chk("uu_dout", 32'(dv), 32'hFE01);
    chk("uu_ovf", 32'(ov), 0);

    // Back-to-back stream of 10 beats
    nout = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #2;
      if (c < 10) drive(1'b1, 8'(c * 17 + 3), 8'(c * 5 + 200), 1'b0, 1'b0);
      else in_valid = 1'b0;
      @(negedge clk);
      if (ov_w[0]) begin
        e = model(8'(nout * 17 + 3), 8'(nout * 5 + 200), 1'b0, 1'b0, 16);
        chk("stream_dout", 32'(dv_w[0]), 32'(e.dout));
        if (first < 0) first = c;
        last = c;
        nout++;
      end
    end
    chk("stream_count", 32'(nout), 10);
    chk("stream_span", 32'(last - first + 1), 10);

    // Signed modes on the 16-bit instance
    one_beat(0, 8'h80, 8'h80, 1'b1, 1'b1, lat, dv, ov);
    chk("ss_dout", 32'(dv), 32'h4000);
    chk("ss_ovf", 32'(ov), 0);
    one_beat(0, 8'hFF, 8'd255, 1'b1, 1'b0, lat, dv, ov);
    chk("su_dout", 32'(dv), 32'hFF01);
    chk("su_ovf", 32'(ov), 0);
    one_beat(0, 8'd255, 8'h80, 1'b0, 1'b1, lat, dv, ov);
    chk("us_dout", 32'(dv), 32'h8080);
    chk("us_ovf", 32'(ov), 0);

    // 12-bit result, single stage: overflow handling
    one_beat(1, 8'd100, 8'd100, 1'b1, 1'b1, lat, dv, ov);
    chk("n1_lat", 32'(lat), 1);
    chk("ovf_pos_dout", 32'(dv), SAT ? 32'h7FF : 32'h710);
    chk("ovf_pos_flag", 32'(ov), 1);
    one_beat(1, 8'h9C, 8'd100, 1'b1, 1'b1, lat, dv, ov);
    chk("ovf_neg_dout", 32'(dv), SAT ? 32'h800 : 32'h8F0);
    chk("ovf_neg_flag", 32'(ov), 1);
    one_beat(1, 8'd255, 8'd255, 1'b0, 1'b0, lat, dv, ov);
    chk("ovf_uu_dout", 32'(dv), SAT ? 32'hFFF : 32'hE01);
    chk("ovf_uu_flag", 32'(ov), 1);

    // Deepest pipe latency
    one_beat(2, 8'h7F, 8'h80, 1'b1, 1'b1, lat, dv, ov);
    chk("n8_lat", 32'(lat), 8);
    chk("n8_dout", 32'(dv), SAT ? 32'h800 : 32'h080);
    chk("n8_ovf", 32'(ov), 1);

    // Backpressure with a full pipe
    idle(12);
    out_ready = 1'b0;
    e = '0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      if (c == 0) e = model(a, b, s0, s1, 16);
      @(negedge clk);
      chk("bp_fill_ready", 32'(rdy_w[0]), 1);
      @(posedge clk); #2;
    end
    @(negedge clk);
    chk("bp_head_valid", 32'(ov_w[0]), 1);
    chk("bp_head_dout", 32'(dv_w[0]), 32'(e.dout));
    snap = dv_w[0];
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #2;
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      chk("bp_in_ready", 32'(rdy_w[0]), 0);
      chk("bp_valid_held", 32'(ov_w[0]), 1);
      chk("bp_dout_stable", 32'(dv_w[0]), 32'(snap));
    end
    @(posedge clk); #2;
    out_ready = 1'b1;
    repeat (4) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    idle(15);

    // Reset with beats in flight
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(ov_w[0]), 1);
    rst_n = 1'b0;
    g_mon[0].q.delete();
    g_mon[1].q.delete();
    g_mon[2].q.delete();
    #1;
    chk("rst_flush_a", 32'(ov_w[0]), 0);
    chk("rst_flush_b", 32'(ov_w[1]), 0);
    chk("rst_flush_c", 32'(ov_w[2]), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(ov_w[0] | ov_w[1] | ov_w[2]), 0);
      @(posedge clk); #2;
    end

    // Random traffic, random backpressure
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #2;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(25);
    chk("sb0_left", 32'(g_mon[0].q.size()), 0);
    chk("sb1_left", 32'(g_mon[1].q.size()), 0);
    chk("sb2_left", 32'(g_mon[2].q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
